bin2bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit per clock.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bin2bcd_seq_if.sv | 25 ++
 rtl/bcd_add3.sv | 10 +
 rtl/bin2bcd_seq.sv | 100 ++++++++++
 tb/tb_bin2bcd_seq.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM encoding, the blank nibble code and the saturation helper.
package bcd_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // Largest value representable in the given number of decimal digits.
  function automatic int max_val(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake bundle between a requester and bin2bcd_seq.
// The master drives the request; the slave (converter) returns the result.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);

  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction step for one BCD nibble.
// Nibbles of 5 or more get 3 added so the next shift carries correctly.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Optional build macro: BLANK_LEADING_ZEROS_EN (blank leading zero digits).
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input logic          mclk,
  input logic          reset,
  bin2bcd_seq_if.slave bus
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(max_val(DIGITS));
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(BIN_W - 1);

  state_t           state;
  logic [BIN_W-1:0] shreg;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    adj;
  logic [SW-1:0]    shown;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib (scratch[4*g +: 4]),
      .adj (adj[4*g +: 4])
    );
  end

`ifdef BLANK_LEADING_ZEROS_EN
  logic lead;

  // Blank zero digits from the MS side until the first nonzero; digit 0 stays.
  always_comb begin
    shown = scratch;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && scratch[4*i +: 4] == 4'd0)
        shown[4*i +: 4] = BLANK_CODE;
      else
        lead = 1'b0;
    end
  end
`else
  // Raw BCD straight from the scratch register.
  always_comb begin
    shown = scratch;
  end
`endif

  // Conversion FSM: capture, BIN_W shift steps, then publish the result.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      scratch      <= '0;
      cnt          <= '0;
      sat          <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.bcd_out  <= '0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sat      <= (bus.bin_in > MAX_VAL);
            shreg    <= (bus.bin_in > MAX_VAL) ? MAX_VAL : bus.bin_in;
            scratch  <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {adj[SW-2:0], shreg, 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          bus.bcd_out  <= shown;
          bus.overflow <= sat;
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq.
// Expected BCD values follow BLANK_LEADING_ZEROS_EN when it is defined.
module tb_bin2bcd_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bin2bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus ();

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .mclk  (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BLANK_LEADING_ZEROS_EN
  localparam logic [15:0] E1234 = 16'h1234;
  localparam logic [15:0] E0    = 16'hFFF0;
  localparam logic [15:0] E7    = 16'hFFF7;
  localparam logic [15:0] E500  = 16'hF500;
`else
  localparam logic [15:0] E1234 = 16'h1234;
  localparam logic [15:0] E0    = 16'h0000;
  localparam logic [15:0] E7    = 16'h0007;
  localparam logic [15:0] E500  = 16'h0500;
`endif

  // Decimal reference: saturate, split into digits, optionally blank.
  function automatic logic [15:0] bcd_ref(input int v);
    int x;
    logic [15:0] r;
    x = (v > 9999) ? 9999 : v;
    r = {4'(x / 1000 % 10), 4'(x / 100 % 10),
         4'(x / 10 % 10), 4'(x % 10)};
`ifdef BLANK_LEADING_ZEROS_EN
    if (x < 1000) r[15:12] = 4'hF;
    if (x < 100)  r[11:8]  = 4'hF;
    if (x < 10)   r[7:4]   = 4'hF;
`endif
    return r;
  endfunction

  task automatic run_conv(
    input  logic [13:0] v,
    output logic [15:0] bcd,
    output logic        ovf,
    output int          lat,
    output int          busyc,
    output bit          seen
  );
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(negedge clk);
    bus.start = 1'b0;
    seen  = 1'b0;
    lat   = 0;
    busyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busyc++;
      @(negedge clk);
      lat++;
    end
    bcd = bus.bcd_out;
    ovf = bus.overflow;
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    end
    total++;
    if (bus.bcd_out !== 16'h0000 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: bcd=%h ovf=%b want 0000 0",
               bus.bcd_out, bus.overflow);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] b;
    logic o;
    int l, bc;
    bit s;
    run_conv(14'd1234, b, o, l, bc, s);
    total++;
    if (s !== 1'b1) begin
      bad++;
      $display("FAIL basic_done: seen=%b want 1", s);
    end
    total++;
    if (b !== E1234 || o !== 1'b0) begin
      bad++;
      $display("FAIL basic_bcd: got %h/%b want %h/0", b, o, E1234);
    end
    total++;
    if (l != 15) begin
      bad++;
      $display("FAIL basic_latency: got %0d want 15", l);
    end
    total++;
    if (bc != 15) begin
      bad++;
      $display("FAIL basic_busy: got %0d want 15", bc);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.bcd_out !== E1234) begin
      bad++;
      $display("FAIL basic_hold: done=%b bcd=%h want 0 %h",
               bus.done, bus.bcd_out, E1234);
    end
  endtask

  task automatic test_small;
    logic [15:0] b;
    logic o;
    int l, bc;
    bit s;
    run_conv(14'd0, b, o, l, bc, s);
    total++;
    if (!s || b !== E0 || o !== 1'b0) begin
      bad++;
      $display("FAIL zero: seen=%b got %h/%b want %h/0", s, b, o, E0);
    end
    run_conv(14'd7, b, o, l, bc, s);
    total++;
    if (!s || b !== E7 || o !== 1'b0) begin
      bad++;
      $display("FAIL seven: seen=%b got %h/%b want %h/0", s, b, o, E7);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] b;
    logic o;
    int l, bc;
    bit s;
    run_conv(14'd16383, b, o, l, bc, s);
    total++;
    if (!s || b !== 16'h9999 || o !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sat: seen=%b got %h/%b want 9999/1", s, b, o);
    end
    run_conv(14'd9999, b, o, l, bc, s);
    total++;
    if (!s || b !== 16'h9999 || o !== 1'b0) begin
      bad++;
      $display("FAIL ovf_max: seen=%b got %h/%b want 9999/0", s, b, o);
    end
  endtask

  task automatic test_ignore;
    int nd;
    bit late;
    nd   = 0;
    late = 1'b0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 14'd500;
    @(negedge clk);
    for (int c = 1; c <= 40; c++) begin
      if (c == 3 || c == 15) begin
        bus.start  = 1'b1;
        bus.bin_in = 14'd42;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) nd++;
      if (c > 16 && bus.busy) late = 1'b1;
      @(negedge clk);
    end
    total++;
    if (nd != 1) begin
      bad++;
      $display("FAIL ignore_dones: got %0d want 1", nd);
    end
    total++;
    if (bus.bcd_out !== E500) begin
      bad++;
      $display("FAIL ignore_bcd: got %h want %h", bus.bcd_out, E500);
    end
    total++;
    if (late) begin
      bad++;
      $display("FAIL ignore_busy: busy after done got 1 want 0");
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] b;
    logic o;
    int l, bc, nd;
    bit s, bz;
    nd = 0;
    bz = 1'b0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 14'd4321;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) nd++;
      if (bus.busy) bz = 1'b1;
    end
    total++;
    if (nd != 0 || bz) begin
      bad++;
      $display("FAIL rstmid_idle: dones=%0d busy=%b want 0 0", nd, bz);
    end
    total++;
    if (bus.bcd_out !== 16'h0000 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_out: got %h/%b want 0000/0",
               bus.bcd_out, bus.overflow);
    end
    run_conv(14'd4321, b, o, l, bc, s);
    total++;
    if (!s || b !== 16'h4321 || o !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_fresh: seen=%b got %h/%b want 4321/0",
               s, b, o);
    end
  endtask

  task automatic test_back_to_back;
    int q[$];
    int v, got, last, cap;
    bit prevb;
    logic [15:0] e;
    v     = 0;
    got   = 0;
    last  = -1;
    @(negedge clk);
    bus.bin_in = 14'd0;
    bus.start  = 1'b1;
    prevb      = bus.busy;
    for (int c = 0; c < 2000 && got < 100; c++) begin
      @(negedge clk);
      if (bus.busy && !prevb) begin
        q.push_back(v);
        v = (v == 99) ? 0 : v + 1;
        bus.bin_in = 14'(v);
      end
      if (bus.done) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_queue: done with no capture");
        end else begin
          cap = q.pop_front();
          e   = bcd_ref(cap);
          if (bus.bcd_out !== e) begin
            bad++;
            $display("FAIL b2b_bcd: val=%0d got %h want %h",
                     cap, bus.bcd_out, e);
          end
        end
        if (last >= 0) begin
          total++;
          if (c - last != 16) begin
            bad++;
            $display("FAIL b2b_period: got %0d want 16", c - last);
          end
        end
        last = c;
        got++;
      end
      prevb = bus.busy;
    end
    bus.start = 1'b0;
    total++;
    if (got != 100) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 100", got);
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_small();
    test_overflow();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
